// File: rtl/bagman_input.sv
// Bagman control front end: merges PS/2 key latches with two joysticks into one
// active-high control word, with a timed coin pulse generator on the coin bit.
module bagman_input #(
    parameter int COIN_PULSE = 120000,
    parameter int COIN_GAP   = 240000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic [6:0]  joy_pcfrldu,
    output logic        coin_busy
);

    localparam int MAXP = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int NEED = $clog2(MAXP + 1);
    localparam int CW   = (NEED > 18) ? NEED : 18;
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);

    generate
        if (COIN_PULSE < 1 || COIN_GAP < 1) begin : g_bad_param
            $error("bagman_input: COIN_PULSE and COIN_GAP must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_HOLD} coin_st_t;

    logic          r_tog;
    logic          r_key_up, r_key_down, r_key_left, r_key_right;
    logic          r_key_fire, r_key_start, r_key_coin;
    logic [5:0]    r_out;
    logic          r_coin;
    logic          r_coin_prev;
    coin_st_t      r_st;
    logic [CW-1:0] r_cnt;

    logic          w_event, w_pressed, w_ext;
    logic [8:0]    w_code;
    logic [15:0]   w_joy;
    logic          w_up, w_down, w_left, w_right;
    logic          w_coin_req;
    logic          w_unused;

    assign w_unused = ^{w_joy[15:7]};

    // A key event is any change of the toggle bit since the previous cycle.
    assign w_event   = ps2_key[64] != r_tog;
    assign w_pressed = ps2_key[15:8] != 8'hF0;
    assign w_ext     = w_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    assign w_code    = (ps2_key[63:24] != '0) ? 9'h000 : {w_ext, ps2_key[7:0]};

    always_ff @(posedge clk_sys) begin
        r_tog <= ps2_key[64];
        if (reset) begin
            r_key_up    <= 1'b0;
            r_key_down  <= 1'b0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
            r_key_fire  <= 1'b0;
            r_key_start <= 1'b0;
            r_key_coin  <= 1'b0;
        end else if (w_event) begin
            // Directions ignore the extended prefix; buttons must match exactly.
            if (w_code[7:0] == 8'h75) r_key_up    <= w_pressed;
            if (w_code[7:0] == 8'h72) r_key_down  <= w_pressed;
            if (w_code[7:0] == 8'h6B) r_key_left  <= w_pressed;
            if (w_code[7:0] == 8'h74) r_key_right <= w_pressed;
            if (w_code == 9'h029)     r_key_fire  <= w_pressed;
            if (w_code == 9'h005)     r_key_start <= w_pressed;
            if (w_code == 9'h004)     r_key_coin  <= w_pressed;
        end
    end

    assign w_joy   = joystick_0 | joystick_1;
    assign w_up    = rotate ? (r_key_left  | w_joy[1]) : (r_key_up    | w_joy[3]);
    assign w_down  = rotate ? (r_key_right | w_joy[0]) : (r_key_down  | w_joy[2]);
    assign w_left  = rotate ? (r_key_down  | w_joy[2]) : (r_key_left  | w_joy[1]);
    assign w_right = rotate ? (r_key_up    | w_joy[3]) : (r_key_right | w_joy[0]);

    always_ff @(posedge clk_sys) begin
        if (reset) r_out <= '0;
        else       r_out <= {r_key_start | w_joy[5], r_key_fire | w_joy[4],
                             w_right, w_left, w_down, w_up};
    end

    assign w_coin_req = r_key_coin | w_joy[6];

    // Previous-coin resets high so a level held through reset never fires.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_st        <= S_IDLE;
            r_cnt       <= '0;
            r_coin      <= 1'b0;
            r_coin_prev <= 1'b1;
        end else begin
            r_coin_prev <= w_coin_req;
            case (r_st)
                S_IDLE: if (w_coin_req && !r_coin_prev) begin
                    r_st   <= S_PULSE;
                    r_cnt  <= '0;
                    r_coin <= 1'b1;
                end
                S_PULSE: if (r_cnt == PULSE_LAST) begin
                    r_st   <= S_GAP;
                    r_cnt  <= '0;
                    r_coin <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_GAP: if (r_cnt == GAP_LAST) r_st <= S_HOLD;
                       else                   r_cnt <= r_cnt + 1'b1;
                S_HOLD: if (!w_coin_req) r_st <= S_IDLE;
                default: r_st <= S_IDLE;
            endcase
        end
    end

    assign joy_pcfrldu = {r_coin, r_out};
    assign coin_busy   = r_st != S_IDLE;

endmodule

// File: doc/bagman_input.md
BAGMAN_INPUT -- requirements
Module: bagman_input

Interface
REQ-001 SHALL have parameter COIN_PULSE, default 120000, coin-high duration in clk_sys cycles (10 ms at 12 MHz).
REQ-002 SHALL have parameter COIN_GAP, default 240000, minimum coin-low time in cycles after each pulse.
REQ-003 SHALL have port clk_sys, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port ps2_key, input, 65: [64] toggles per event, [63:24] extra bytes, [23:8] prefix bytes, [7:0] scan code.
REQ-006 SHALL have port joystick_0, input, 16, player-1 buttons.
REQ-007 SHALL have port joystick_1, input, 16, player-2 buttons.
  - Bits: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start, [6] coin.
REQ-008 SHALL have port rotate, input, 1, horizontal-orientation remap enable.
REQ-009 SHALL have port joy_pcfrldu, output, 7, registered: [6] coin, [5] start, [4] fire, [3] right, [2] left, [1] down, [0] up.
REQ-010 SHALL have port coin_busy, output, 1, high whenever the coin FSM is not IDLE.

Function
REQ-011 SHALL register ps2_key[64] each cycle and treat any difference between registered and current value as one key event.
REQ-012 SHALL decode per event:
  - pressed = (ps2_key[15:8] != F0).
  - extended = pressed ? (ps2_key[15:8] == E0) : (ps2_key[23:16] == E0).
  - code = {extended, ps2_key[7:0]}, forced to 0 when ps2_key[63:24] != 0.
REQ-013 SHALL latch key state = pressed on the event cycle; new state visible at latch outputs one cycle later.
REQ-014 Key map:
  - Extended bit ignored: 75 up, 72 down, 6B left, 74 right.
  - Exact match required: 029 fire, 005 start (F1), 004 coin (F3).
  - All other codes SHALL change nothing.
REQ-015 SHALL OR joystick_0 and joystick_1 bitwise into joy.
REQ-016 rotate=0 SHALL map:
  - up = key_up | joy[3]; down = key_down | joy[2].
  - left = key_left | joy[1]; right = key_right | joy[0].
REQ-017 rotate=1 SHALL map:
  - up = key_left | joy[1]; down = key_right | joy[0].
  - left = key_down | joy[2]; right = key_up | joy[3].
REQ-018 SHALL set fire = key_fire | joy[4] and start = key_start | joy[5].
REQ-019 joy_pcfrldu[5:0] SHALL be registered with exactly one cycle latency from latch/joystick/rotate inputs.
REQ-020 SHALL form coin_req = key_coin | joy[6] and run coin FSM states IDLE, PULSE, GAP, HOLD.
REQ-021 IDLE:
  - On coin_req rising edge (registered previous value 0, current 1): go to PULSE and clear counter.
  - A level already high on leaving reset SHALL NOT trigger.
REQ-022 PULSE: joy_pcfrldu[6] SHALL be 1; after exactly COIN_PULSE cycles, go to GAP and clear counter.
REQ-023 GAP: joy_pcfrldu[6] SHALL be 0; after COIN_GAP cycles, go to HOLD.
REQ-024 HOLD: SHALL return to IDLE when coin_req=0; stay while coin_req=1, so one press gives one pulse.
REQ-025 Coin edges arriving in PULSE or GAP SHALL be ignored, not queued.
REQ-026 Counter SHALL be 18 bits minimum, saturating-free; parameters SHALL be at least 1.
REQ-027 Simultaneous key event and joystick change on the same cycle SHALL both take effect; output is the OR.

Reset
REQ-028 While reset=1:
  - All key latches = 0; joy_pcfrldu = 0; coin FSM = IDLE; counter = 0; coin_busy = 0.
  - Previous-coin register = 1.
  - ps2_key[64] SHALL be sampled into its register so no spurious event fires on release.
REQ-029 Reset asserted during PULSE SHALL drop the coin bit on the next edge; no pulse resumes after release.

Verification
REQ-030 Bench SHALL cover these directed scenarios (COIN_PULSE=4, COIN_GAP=3 where noted):
  - S1: event 0x000075 toggled -> joy_pcfrldu[0]=1 two cycles later; event 0x00F075 -> back to 0.
  - S2: event 0xE0F075 (extended break) after 0x00E075 -> up clears; 0x0000029 sets fire only.
  - S3: rotate=1, joystick_0=0x0008 -> joy_pcfrldu=0x08 (right) one cycle later; rotate=0 -> 0x01.
  - S4 (4/3): joystick_1[6] held 20 cycles -> coin high exactly 4 cycles, then low; no second pulse until release.
  - S5 (4/3): F3 pressed, released, re-pressed during GAP -> single pulse only; re-press after HOLD->IDLE -> second pulse.
  - S6: reset mid-PULSE, ps2_key[64] toggled during reset -> all outputs 0, no key latched after release.
